// File: rtl/mem_responder_rv.sv
// Memory-side responder for the RV core split bus: word RAM, lane-shifted stores, and an MMIO
// window with a TX byte FIFO, cycle counter and sticky status. Optional: MEM_RESPONDER_RV_CYCLE_COUNTER_EN.
module mem_responder_rv #(
    parameter int unsigned MEM_WORDS_LOG2  = 10,
    parameter logic [31:0] MMIO_BASE       = 32'hF000_0000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic [31:0] iwRead1Addr,
    input  logic [31:0] iwRead2Addr,
    input  logic [31:0] iwWriteAddr,
    input  logic [31:0] iwWriteData,
    input  logic [3:0]  iwWstrb,
    output logic [31:0] owRead1Data,
    output logic [31:0] owRead2Data,
    output logic [7:0]  owTxData,
    output logic        owTxValid,
    input  logic        iwTxReady,
    output logic        owFault
);

    localparam int unsigned RAM_AW     = MEM_WORDS_LOG2 + 2;
    localparam int unsigned MEM_WORDS  = 1 << MEM_WORDS_LOG2;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW         = FIFO_DEPTH_LOG2 + 1;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam logic [3:0]  OFF_TX     = 4'h0;
    localparam logic [3:0]  OFF_CYC    = 4'h1;
    localparam logic [3:0]  OFF_STAT   = 4'h2;

    logic [31:0] r_mem  [0:MEM_WORDS-1];
    logic [7:0]  r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic        r_ovf;
    logic        r_fault;

    logic        w_r1_ok;
    logic        w_r2_ram;
    logic        w_r2_mmio;
    logic        w_r2_fault;
    logic [31:0] w_rd2;
    logic [31:0] w_cycle_rd;

    logic [1:0]  w_off;
    logic [3:0]  w_strb_eff;
    logic [31:0] w_data_sh;
    logic        w_wr_any;
    logic        w_legal;
    logic        w_wr_ram;
    logic        w_wr_mmio;
    logic        w_wr_ok;
    logic        w_wr_fault;
    logic        w_ram_we;
    logic        w_mmio_we;
    logic [3:0]  w_wr_idx;

    logic        w_empty;
    logic        w_full;
    logic [PW-1:0] w_occ;
    logic        w_pop;
    logic        w_push;
    logic        w_push_ok;
    logic        w_ovf_ev;
    logic        w_fault_ev;
    logic [1:0]  w_stat_clr;
    logic        w_unused;

    // Instruction fetch: only aligned RAM words are legal, anything else yields a NOP
    assign w_r1_ok     = (iwRead1Addr[31:RAM_AW] == '0) && (iwRead1Addr[1:0] == 2'b00);
    assign owRead1Data = w_r1_ok ? r_mem[iwRead1Addr[RAM_AW-1:2]] : NOP_INSN;

    assign w_r2_ram  = (iwRead2Addr[31:RAM_AW] == '0);
    assign w_r2_mmio = (iwRead2Addr[31:6] == MMIO_BASE[31:6]);

    // FIFO status
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                     (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign w_occ   = r_wptr - r_rptr;

    always_comb begin
        w_rd2      = '0;
        w_r2_fault = 1'b0;
        if (w_r2_ram) begin
            w_rd2 = r_mem[iwRead2Addr[RAM_AW-1:2]];
        end else if (w_r2_mmio) begin
            case (iwRead2Addr[5:2])
                OFF_TX:   w_rd2 = {24'b0, 4'(w_occ), 1'b0, r_ovf, w_full, w_empty};
                OFF_CYC:  w_rd2 = w_cycle_rd;
                OFF_STAT: w_rd2 = {30'b0, r_fault, r_ovf};
                default:  w_rd2 = '0;
            endcase
        end else begin
            w_r2_fault = 1'b1;
        end
    end

    assign owRead2Data = w_rd2;

    // Store lane shift and legality
    assign w_off      = iwWriteAddr[1:0];
    assign w_strb_eff = 4'(iwWstrb << w_off);
    assign w_data_sh  = iwWriteData << {w_off, 3'b000};
    assign w_wr_any   = (iwWstrb != 4'b0000);
    assign w_legal    = (iwWstrb == 4'b0001) ||
                        ((iwWstrb == 4'b0011) && !w_off[0]) ||
                        ((iwWstrb == 4'b1111) && (w_off == 2'b00));
    assign w_wr_ram   = (iwWriteAddr[31:RAM_AW] == '0);
    assign w_wr_mmio  = (iwWriteAddr[31:6] == MMIO_BASE[31:6]);
    assign w_wr_ok    = w_wr_any && w_legal && (w_wr_ram || w_wr_mmio);
    assign w_wr_fault = w_wr_any && !(w_legal && (w_wr_ram || w_wr_mmio));
    assign w_ram_we   = w_wr_ok && w_wr_ram;
    assign w_mmio_we  = w_wr_ok && !w_wr_ram && w_wr_mmio;
    assign w_wr_idx   = iwWriteAddr[5:2];

    assign w_push     = w_mmio_we && (w_wr_idx == OFF_TX) && w_strb_eff[0];
    assign w_pop      = !w_empty && iwTxReady;
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_ovf_ev   = w_push && w_full && !w_pop;
    assign w_stat_clr = (w_mmio_we && (w_wr_idx == OFF_STAT) && w_strb_eff[0]) ?
                        w_data_sh[1:0] : 2'b00;
    assign w_fault_ev = !w_r1_ok || w_r2_fault || w_wr_fault;

    assign owTxValid = !w_empty;
    assign owTxData  = w_empty ? 8'h00 : r_fifo[r_rptr[PW-2:0]];
    assign owFault   = r_fault;

    // RAM byte-lane commit; reads above see the pre-edge contents
    always_ff @(posedge iwClk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_eff[i]) begin
                    r_mem[iwWriteAddr[RAM_AW-1:2]][8*i +: 8] <= w_data_sh[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge iwClk) begin
        if (w_push_ok) begin
            r_fifo[r_wptr[PW-2:0]] <= w_data_sh[7:0];
        end
    end

    // FIFO pointers and sticky flags; a new event beats a same-cycle clear
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            r_ovf   <= w_ovf_ev   || (r_ovf   && !w_stat_clr[0]);
            r_fault <= w_fault_ev || (r_fault && !w_stat_clr[1]);
        end
    end

`ifdef MEM_RESPONDER_RV_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;
    logic        w_cyc_clr;

    assign w_cyc_clr  = w_mmio_we && (w_wr_idx == OFF_CYC);
    assign w_cycle_rd = r_cycle;

    // Free-running counter; a write clears it and beats the increment
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_cycle <= '0;
        end else if (w_cyc_clr) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`else
    assign w_cycle_rd = '0;
`endif

    // Data reads are word-aligned by the core, so the low address bits carry no information
    assign w_unused = ^iwRead2Addr[1:0];

endmodule

// File: tb/tb_mem_responder_rv.sv
// Self-checking bench for mem_responder_rv: byte-addressed memory / queue model compared every
// cycle, plus directed literal expectations. Honours MEM_RESPONDER_RV_CYCLE_COUNTER_EN.
module tb_mem_responder_rv;

    localparam logic [31:0] BASE      = 32'hF000_0000;
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk;
    logic        iwnRst;
    logic [31:0] iwRead1Addr;
    logic [31:0] iwRead2Addr;
    logic [31:0] iwWriteAddr;
    logic [31:0] iwWriteData;
    logic [3:0]  iwWstrb;
    logic [31:0] owRead1Data;
    logic [31:0] owRead2Data;
    logic [7:0]  owTxData;
    logic        owTxValid;
    logic        iwTxReady;
    logic        owFault;

    int n_checks = 0;
    int n_err    = 0;

    mem_responder_rv dut (
        .iwClk       (clk),
        .iwnRst      (iwnRst),
        .iwRead1Addr (iwRead1Addr),
        .iwRead2Addr (iwRead2Addr),
        .iwWriteAddr (iwWriteAddr),
        .iwWriteData (iwWriteData),
        .iwWstrb     (iwWstrb),
        .owRead1Data (owRead1Data),
        .owRead2Data (owRead2Data),
        .owTxData    (owTxData),
        .owTxValid   (owTxValid),
        .iwTxReady   (iwTxReady),
        .owFault     (owFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: bytes by address, TX queue, counter, sticky flags
    logic [7:0]  m_mem [int unsigned];
    logic [7:0]  m_q [$];
    logic [31:0] m_cyc;
    bit          m_ovf;
    bit          m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return a < RAM_BYTES;
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd64);
    endfunction

    function automatic int unsigned store_size(input logic [3:0] s);
        case (s)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit ram_word(input logic [31:0] a, output logic [31:0] w);
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (!m_mem.exists(a + 32'(k))) return 1'b0;
            w[8*k +: 8] = m_mem[a + 32'(k)];
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] mmio_read(input logic [31:0] a);
        int unsigned idx;
        int unsigned n;
        idx = (a - BASE) / 4;
        n   = m_q.size();
        case (idx)
            0: return {24'b0, 4'(n), 1'b0, m_ovf, (n == 8), (n == 0)};
`ifdef MEM_RESPONDER_RV_CYCLE_COUNTER_EN
            1: return m_cyc;
`endif
            2: return {30'b0, m_fault, m_ovf};
            default: return 32'h0;
        endcase
    endfunction

    // Model update on each edge, from the inputs present before the edge
    bit          u_fev, u_oev, u_push, u_pop, u_cclr;
    logic [1:0]  u_sclr;
    int unsigned u_sz;
    logic [31:0] u_off;
    always @(posedge clk or negedge iwnRst) begin
        if (!iwnRst) begin
            m_q.delete();
            m_cyc   = '0;
            m_ovf   = 1'b0;
            m_fault = 1'b0;
        end else begin
            u_fev = 1'b0; u_oev = 1'b0; u_push = 1'b0; u_cclr = 1'b0; u_sclr = 2'b00;
            if (!(in_ram(iwRead1Addr) && iwRead1Addr[1:0] == 2'b00)) u_fev = 1'b1;
            if (!in_ram(iwRead2Addr) && !in_mmio(iwRead2Addr)) u_fev = 1'b1;
            if (iwWstrb != 4'b0000) begin
                u_sz = store_size(iwWstrb);
                if (u_sz == 0 || (iwWriteAddr % u_sz) != 0 ||
                    !(in_ram(iwWriteAddr) || in_mmio(iwWriteAddr))) begin
                    u_fev = 1'b1;
                end else if (in_ram(iwWriteAddr)) begin
                    for (int k = 0; k < int'(u_sz); k++)
                        m_mem[iwWriteAddr + 32'(k)] = iwWriteData[8*k +: 8];
                end else begin
                    u_off = iwWriteAddr - BASE;
                    if (u_off == 0) u_push = 1'b1;
                    if (u_off / 4 == 1) u_cclr = 1'b1;
                    if (u_off == 8) u_sclr = iwWriteData[1:0];
                end
            end
            u_pop = (m_q.size() > 0) && iwTxReady;
            if (u_pop) void'(m_q.pop_front());
            if (u_push) begin
                if (m_q.size() < 8) m_q.push_back(iwWriteData[7:0]);
                else u_oev = 1'b1;
            end
            m_cyc   = u_cclr ? 32'h0 : m_cyc + 32'd1;
            m_ovf   = u_oev || (m_ovf && !u_sclr[0]);
            m_fault = u_fev || (m_fault && !u_sclr[1]);
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    logic [31:0] c_e;
    bit          c_k;
    always @(negedge clk) begin
        if (in_ram(iwRead1Addr) && iwRead1Addr[1:0] == 2'b00) c_k = ram_word(iwRead1Addr, c_e);
        else begin c_k = 1'b1; c_e = NOP; end
        if (c_k) chk("model_read1", owRead1Data, c_e);
        if (in_ram(iwRead2Addr)) c_k = ram_word(iwRead2Addr & 32'hFFFF_FFFC, c_e);
        else if (in_mmio(iwRead2Addr)) begin c_k = 1'b1; c_e = mmio_read(iwRead2Addr); end
        else begin c_k = 1'b1; c_e = 32'h0; end
        if (c_k) chk("model_read2", owRead2Data, c_e);
        chk("model_txvalid", 32'(owTxValid), 32'(m_q.size() != 0));
        chk("model_txdata", 32'(owTxData), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        chk("model_fault", 32'(owFault), 32'(m_fault));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        iwWriteAddr = a;
        iwWriteData = d;
        iwWstrb     = s;
        cyc();
        iwWstrb = 4'b0000;
    endtask

    logic [7:0]  exp_q [8];
    logic [31:0] v1, v2;

    initial begin
        iwnRst = 1'b0; iwRead1Addr = '0; iwRead2Addr = '0;
        iwWriteAddr = '0; iwWriteData = '0; iwWstrb = '0; iwTxReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txvalid", 32'(owTxValid), 32'h0);
        chk("rst_txdata", 32'(owTxData), 32'h0);
        chk("rst_fault", 32'(owFault), 32'h0);
        cyc();
        iwnRst = 1'b1;
        cyc();

        // Word store then read back on both ports
        wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
        iwRead1Addr = 32'h10; iwRead2Addr = 32'h10;
        @(negedge clk);
        chk("word_rd2", owRead2Data, 32'hDEAD_BEEF);
        chk("word_rd1", owRead1Data, 32'hDEAD_BEEF);
        chk("word_fault", 32'(owFault), 32'h0);
        cyc();

        // Byte and half stores with lane shift
        wr(32'h13, 32'h0000_00A5, 4'b0001);
        wr(32'h10, 32'h0000_1234, 4'b0011);
        @(negedge clk);
        chk("lanes_rd2", owRead2Data, 32'hA5AD_1234);
        cyc();

        // Same-cycle read sees old word, new word after the edge
        iwWriteAddr = 32'h10; iwWriteData = 32'h1122_3344; iwWstrb = 4'b1111;
        @(negedge clk);
        chk("rdw_old", owRead2Data, 32'hA5AD_1234);
        cyc();
        iwWstrb = 4'b0000;
        @(negedge clk);
        chk("rdw_new", owRead2Data, 32'h1122_3344);
        cyc();

        // Illegal stores are suppressed and fault; STATUS W1C clears fault
        wr(32'h11, 32'h0000_FFFF, 4'b0011);
        @(negedge clk);
        chk("ill_half_fault", 32'(owFault), 32'h1);
        cyc();
        wr(32'h12, 32'hFFFF_FFFF, 4'b1111);
        @(negedge clk);
        chk("ill_unchanged", owRead2Data, 32'h1122_3344);
        chk("ill_word_fault", 32'(owFault), 32'h1);
        cyc();
        wr(BASE + 32'h8, 32'h2, 4'b1111);
        @(negedge clk);
        chk("stat_clr_fault", 32'(owFault), 32'h0);
        cyc();
        wr(32'h8000_0000, 32'h0, 4'b1111);
        @(negedge clk);
        chk("unmapped_wr_fault", 32'(owFault), 32'h1);
        cyc();
        wr(BASE + 32'h8, 32'h2, 4'b1111);
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
        iwRead2Addr = BASE + 32'hC;
        @(negedge clk);
        chk("unused_off_rd", owRead2Data, 32'h0);
        chk("unused_off_nofault", 32'(owFault), 32'h0);
        cyc();

        // Overfill the FIFO with the sink stalled
        for (int i = 1; i <= 9; i++) wr(BASE, 32'(i), 4'b0001);
        iwRead2Addr = BASE;
        @(negedge clk);
        chk("fifo_full_stat", owRead2Data, 32'h0000_0086);
        cyc();
        wr(BASE + 32'h8, 32'h1, 4'b1111);
        iwTxReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("drain_data", 32'(owTxData), 32'(i));
            cyc();
        end
        @(negedge clk);
        chk("drain_empty", 32'(owTxValid), 32'h0);
        cyc();
        iwTxReady = 1'b0;

        // Push into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 8; i++) wr(BASE, 32'h10 + 32'(i), 4'b0001);
        iwTxReady = 1'b1;
        wr(BASE, 32'h55, 4'b0001);
        for (int i = 0; i < 7; i++) exp_q[i] = 8'h11 + 8'(i);
        exp_q[7] = 8'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("pushpop_stat", owRead2Data, 32'h0000_0082);
            chk("pushpop_data", 32'(owTxData), 32'(exp_q[i]));
            cyc();
        end
        @(negedge clk);
        chk("pushpop_empty", 32'(owTxValid), 32'h0);
        cyc();
        iwTxReady = 1'b0;

`ifdef MEM_RESPONDER_RV_CYCLE_COUNTER_EN
        iwRead2Addr = BASE + 32'h4;
        @(negedge clk);
        v1 = owRead2Data;
        repeat (5) cyc();
        @(negedge clk);
        v2 = owRead2Data;
        chk("cycle_delta", v2 - v1, 32'd5);
        cyc();
        wr(BASE + 32'h4, 32'h0, 4'b1111);
        @(negedge clk);
        chk("cycle_clr", owRead2Data, 32'h0);
        cyc();
        @(negedge clk);
        chk("cycle_after_clr", owRead2Data, 32'h1);
        cyc();
`else
        iwRead2Addr = BASE + 32'h4;
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111);
        @(negedge clk);
        v1 = owRead2Data;
        chk("cycle_off_rd", v1, 32'h0);
        chk("cycle_off_nofault", 32'(owFault), 32'h0);
        cyc();
`endif

        // Fetch from MMIO and misaligned fetch return NOP and fault
        iwRead1Addr = BASE;
        @(negedge clk);
        chk("fetch_mmio", owRead1Data, NOP);
        cyc();
        iwRead1Addr = 32'h2;
        @(negedge clk);
        chk("fetch_misalign", owRead1Data, NOP);
        chk("fetch_fault", 32'(owFault), 32'h1);
        cyc();
        iwRead1Addr = 32'h10;
        wr(BASE + 32'h8, 32'h2, 4'b1111);
        @(negedge clk);
        chk("fetch_clr", 32'(owFault), 32'h0);
        cyc();

        // Unmapped data read
        iwRead2Addr = 32'h4000_0000;
        @(negedge clk);
        chk("rd2_unmapped", owRead2Data, 32'h0);
        cyc();
        iwRead2Addr = 32'h10;
        @(negedge clk);
        chk("rd2_unmapped_fault", 32'(owFault), 32'h1);
        cyc();

        // Last RAM word and first byte beyond RAM
        wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
        wr(32'h1000, 32'h0, 4'b0001);
        iwRead2Addr = 32'hFFC;
        @(negedge clk);
        chk("ram_top", owRead2Data, 32'hCAFE_F00D);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
